writeback_arb: RTL and testbench
================================

WRITEBACK_ARB -- requirements
Module: writeback_arb

Interface
REQ-001 SHALL have parameter P_NUM_PIPES, default 4, number of execute pipes sharing the completion port (legal 1..8).
REQ-002 SHALL have parameter P_SEQ_BITS, default 8, width of the sequence number.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ex_val  input  P_NUM_PIPES  per-pipe completion valid.
REQ-006 SHALL have port ex_rdy  output  P_NUM_PIPES  per-pipe grant/ready.
REQ-007 SHALL have port ex_seq_num  input  P_NUM_PIPES*P_SEQ_BITS  per-pipe sequence number; pipe i occupies slice [i*P_SEQ_BITS +: P_SEQ_BITS].
REQ-008 SHALL have port ex_waddr  input  P_NUM_PIPES*5  per-pipe destination register; pipe i occupies [i*5 +: 5].
REQ-009 SHALL have port ex_wdata  input  P_NUM_PIPES*32  per-pipe result; pipe i occupies [i*32 +: 32].
REQ-010 SHALL have port ex_wen  input  P_NUM_PIPES  per-pipe register-write enable.
REQ-011 SHALL have ports cmp_val (1), cmp_seq_num (P_SEQ_BITS), cmp_waddr (5), cmp_wdata (32), cmp_wen (1), all outputs, forming the registered completion notification broadcast to decode/regfile.
REQ-012 SHALL have port cmp_count  output  32  running count of completions issued.

Function
REQ-013 SHALL keep a round-robin pointer ptr (width clog2(P_NUM_PIPES), minimum 1 bit) naming the highest-priority pipe.
REQ-014 SHALL select as winner the first pipe i with ex_val[i]=1 scanning ptr, ptr+1, ... modulo P_NUM_PIPES.
REQ-015 SHALL drive ex_rdy combinationally, one-hot on the winner, all-zero when no ex_val is set.
REQ-016 SHALL treat ex_val[i] & ex_rdy[i] as a transfer; at most one transfer SHALL occur per cycle.
REQ-017 SHALL not stall transfers, because the completion port has no back-pressure; any cycle with one or more valid pipes SHALL transfer exactly one.
REQ-018 SHALL, on a transfer, load the winner's seq_num, waddr and wdata into the output registers on the next rising edge and set cmp_val=1 for that cycle only (latency 1 cycle).
REQ-019 SHALL register cmp_wen as winner ex_wen AND (winner waddr != 0), so x0 is never written.
REQ-020 SHALL set cmp_val=0 in cycles following a non-transfer cycle; cmp_seq_num, cmp_waddr and cmp_wdata SHALL hold their previous values and cmp_wen SHALL be 0.
REQ-021 SHALL update ptr to (winner+1) mod P_NUM_PIPES on a transfer and hold ptr otherwise.
REQ-022 SHALL guarantee that a pipe holding ex_val continuously is granted within P_NUM_PIPES cycles.
REQ-023 SHALL increment cmp_count by 1 on each transfer, wrapping 0xFFFFFFFF -> 0.
REQ-024 SHALL not let ex_rdy depend on any data field, only on ex_val and ptr.
REQ-025 SHALL, for P_NUM_PIPES=1, reduce to a 1-cycle register with ex_rdy[0]=ex_val[0].

Reset
REQ-026 SHALL, while rst=1, force ex_rdy=0, so no transfer is accepted in a reset cycle, even mid-operation.
REQ-027 SHALL, after a reset edge, hold ptr=0, cmp_val=0, cmp_wen=0, cmp_seq_num=0, cmp_waddr=0, cmp_wdata=0 and cmp_count=0.
REQ-028 SHALL discard a transfer whose output would have appeared in the cycle after a reset edge.

Verification
REQ-029 Single pipe: ex_val=0b0100, pipe2 {seq 5, waddr 3, wdata 0xDEADBEEF, wen 1} -> ex_rdy=0b0100; next cycle cmp_val=1, seq 5, waddr 3, wdata 0xDEADBEEF, wen 1, cmp_count=1, ptr=3.
REQ-030 Fairness: ex_val=0b1111 held for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3 and cmp_count=8.
REQ-031 x0 suppression: pipe0 {waddr 0, wen 1} -> cmp_val=1, cmp_wen=0.
REQ-032 Idle: transfer, then ex_val=0 -> cmp_val=0 and cmp_wen=0, with data fields unchanged from the prior transfer.
REQ-033 Reset mid-stream: ex_val=0b0011 with rst=1 for one cycle -> ex_rdy=0 during reset; next cycle cmp_val=0, ptr=0 and pipe0 granted first.
REQ-034 Count wrap: cmp_count forced to 0xFFFFFFFF by prior transfers, plus one transfer -> cmp_count=0.

Source files
------------

// File: rtl/writeback_arb.sv
// rtl/writeback_arb.sv - round-robin arbiter merging execute-pipe completions onto one registered port
module writeback_arb #(
    parameter int P_NUM_PIPES = 4,
    parameter int P_SEQ_BITS  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [P_NUM_PIPES-1:0]          ex_val,
    output logic [P_NUM_PIPES-1:0]          ex_rdy,
    input  logic [P_NUM_PIPES*P_SEQ_BITS-1:0] ex_seq_num,
    input  logic [P_NUM_PIPES*5-1:0]        ex_waddr,
    input  logic [P_NUM_PIPES*32-1:0]       ex_wdata,
    input  logic [P_NUM_PIPES-1:0]          ex_wen,
    output logic                            cmp_val,
    output logic [P_SEQ_BITS-1:0]           cmp_seq_num,
    output logic [4:0]                      cmp_waddr,
    output logic [31:0]                     cmp_wdata,
    output logic                            cmp_wen,
    output logic [31:0]                     cmp_count
);

    localparam int PTR_W = (P_NUM_PIPES > 1) ? $clog2(P_NUM_PIPES) : 1;
    localparam logic [PTR_W-1:0] LAST_PIPE = PTR_W'(P_NUM_PIPES - 1);

    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       win_idx;
    logic                   win_any;
    logic                   xfer;
    logic                   cmp_val_q;
    logic [P_SEQ_BITS-1:0]  cmp_seq_q;
    logic [4:0]             cmp_waddr_q;
    logic [31:0]            cmp_wdata_q;
    logic                   cmp_wen_q;
    logic [31:0]            cmp_count_q, cmp_count_d;
    logic [P_SEQ_BITS-1:0]  win_seq;
    logic [4:0]             win_waddr;
    logic [31:0]            win_wdata;
    logic                   win_wen;

    // Rotating priority scan starting at ptr; only ex_val and ptr feed the grant.
    always_comb begin
        int unsigned j;
        win_any = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int k = 0; k < P_NUM_PIPES; k++) begin
            j = int'(ptr_q) + k;
            if (j >= P_NUM_PIPES) begin
                j = j - P_NUM_PIPES;
            end
            if (!win_any && ex_val[j]) begin
                win_any = 1'b1;
                win_idx = j[PTR_W-1:0];
            end
        end
    end

    // One-hot grant, suppressed during reset so nothing is accepted in a reset cycle.
    always_comb begin
        ex_rdy = '0;
        xfer   = win_any & ~rst;
        if (xfer) begin
            ex_rdy[win_idx] = 1'b1;
        end
    end

    // Select the winner's payload and compute the pointer/count successors.
    always_comb begin
        win_seq     = ex_seq_num[win_idx*P_SEQ_BITS +: P_SEQ_BITS];
        win_waddr   = ex_waddr[win_idx*5 +: 5];
        win_wdata   = ex_wdata[win_idx*32 +: 32];
        win_wen     = ex_wen[win_idx];
        cmp_count_d = cmp_count_q + 32'd1;
        ptr_d       = ptr_q;
        if (xfer) begin
            ptr_d = (win_idx == LAST_PIPE) ? '0 : win_idx + PTR_W'(1);
        end
    end

    // Completion register: pulse valid for one cycle per transfer, hold data when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cmp_val_q   <= 1'b0;
            cmp_seq_q   <= '0;
            cmp_waddr_q <= '0;
            cmp_wdata_q <= '0;
            cmp_wen_q   <= 1'b0;
            cmp_count_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cmp_val_q <= xfer;
            if (xfer) begin
                cmp_seq_q   <= win_seq;
                cmp_waddr_q <= win_waddr;
                cmp_wdata_q <= win_wdata;
                // x0 is hardwired zero, so a write to it is turned into a no-write.
                cmp_wen_q   <= win_wen & (win_waddr != 5'd0);
                cmp_count_q <= cmp_count_d;
            end else begin
                cmp_wen_q   <= 1'b0;
            end
        end
    end

    assign cmp_val     = cmp_val_q;
    assign cmp_seq_num = cmp_seq_q;
    assign cmp_waddr   = cmp_waddr_q;
    assign cmp_wdata   = cmp_wdata_q;
    assign cmp_wen     = cmp_wen_q;
    assign cmp_count   = cmp_count_q;

endmodule

// File: tb/tb_writeback_arb.sv
// tb/tb_writeback_arb.sv - self-checking bench for writeback_arb
module tb_writeback_arb;

    localparam int N  = 4;
    localparam int SB = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      ex_val;
    logic [N-1:0]      ex_rdy;
    logic [N*SB-1:0]   ex_seq_num;
    logic [N*5-1:0]    ex_waddr;
    logic [N*32-1:0]   ex_wdata;
    logic [N-1:0]      ex_wen;
    logic              cmp_val;
    logic [SB-1:0]     cmp_seq_num;
    logic [4:0]        cmp_waddr;
    logic [31:0]       cmp_wdata;
    logic              cmp_wen;
    logic [31:0]       cmp_count;

    logic [SB-1:0]     seq_a   [N];
    logic [4:0]        waddr_a [N];
    logic [31:0]       wdata_a [N];
    logic              wen_a   [N];

    typedef struct {
        logic [SB-1:0] seq;
        logic [4:0]    waddr;
        logic [31:0]   wdata;
        logic          wen;
    } cmp_t;

    typedef struct {
        logic [3:0] val;
        logic [3:0] rdy;
        logic [1:0] ptr;
    } vec_t;

    cmp_t        sb_q[$];
    cmp_t        last;
    vec_t        tbl[14];
    logic [31:0] exp_count;
    int          n_pass  = 0;
    int          n_total = 0;

    writeback_arb #(.P_NUM_PIPES(N), .P_SEQ_BITS(SB)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_val      (ex_val),
        .ex_rdy      (ex_rdy),
        .ex_seq_num  (ex_seq_num),
        .ex_waddr    (ex_waddr),
        .ex_wdata    (ex_wdata),
        .ex_wen      (ex_wen),
        .cmp_val     (cmp_val),
        .cmp_seq_num (cmp_seq_num),
        .cmp_waddr   (cmp_waddr),
        .cmp_wdata   (cmp_wdata),
        .cmp_wen     (cmp_wen),
        .cmp_count   (cmp_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ex_seq_num[i*SB +: SB] = seq_a[i];
            ex_waddr[i*5 +: 5]     = waddr_a[i];
            ex_wdata[i*32 +: 32]   = wdata_a[i];
            ex_wen[i]              = wen_a[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycle(input logic [3:0] val, input logic r,
                         input logic [3:0] erdy, input logic [1:0] eptr);
        cmp_t e;
        e = '{default: '0};
        @(negedge clk);
        ex_val = val;
        rst    = r;
        #1;
        chk("ex_rdy", 32'(ex_rdy), 32'(erdy));
        if (!r && erdy != 4'd0) begin
            for (int i = 0; i < N; i++) begin
                if (erdy[i]) begin
                    e.seq   = seq_a[i];
                    e.waddr = waddr_a[i];
                    e.wdata = wdata_a[i];
                    e.wen   = wen_a[i] && (waddr_a[i] != 5'd0);
                end
            end
            sb_q.push_back(e);
            exp_count = exp_count + 32'd1;
        end
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            exp_count = 32'd0;
            last      = '{default: '0};
            chk("rst_val",   32'(cmp_val), 32'd0);
            chk("rst_wen",   32'(cmp_wen), 32'd0);
            chk("rst_seq",   32'(cmp_seq_num), 32'd0);
            chk("rst_waddr", 32'(cmp_waddr), 32'd0);
            chk("rst_wdata", cmp_wdata, 32'd0);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("cmp_val",   32'(cmp_val), 32'd1);
            chk("cmp_seq",   32'(cmp_seq_num), 32'(e.seq));
            chk("cmp_waddr", 32'(cmp_waddr), 32'(e.waddr));
            chk("cmp_wdata", cmp_wdata, e.wdata);
            chk("cmp_wen",   32'(cmp_wen), 32'(e.wen));
            last = e;
        end else begin
            chk("idle_val",   32'(cmp_val), 32'd0);
            chk("idle_wen",   32'(cmp_wen), 32'd0);
            chk("idle_seq",   32'(cmp_seq_num), 32'(last.seq));
            chk("idle_waddr", 32'(cmp_waddr), 32'(last.waddr));
            chk("idle_wdata", cmp_wdata, last.wdata);
        end
        chk("cmp_count", cmp_count, exp_count);
        chk("ptr", 32'(dut.ptr_q), 32'(eptr));
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) begin
            seq_a[i]   = SB'($urandom);
            waddr_a[i] = 5'($urandom_range(0, 31));
            wdata_a[i] = $urandom;
            wen_a[i]   = 1'($urandom);
        end
    endtask

    initial begin
        // {ex_val, expected ex_rdy, expected ptr afterwards}, applied from reset.
        tbl[0]  = '{4'b0100, 4'b0100, 2'd3};
        tbl[1]  = '{4'b1111, 4'b1000, 2'd0};
        tbl[2]  = '{4'b1111, 4'b0001, 2'd1};
        tbl[3]  = '{4'b1111, 4'b0010, 2'd2};
        tbl[4]  = '{4'b1111, 4'b0100, 2'd3};
        tbl[5]  = '{4'b0000, 4'b0000, 2'd3};
        tbl[6]  = '{4'b0011, 4'b0001, 2'd1};
        tbl[7]  = '{4'b0011, 4'b0010, 2'd2};
        tbl[8]  = '{4'b0001, 4'b0001, 2'd1};
        tbl[9]  = '{4'b1000, 4'b1000, 2'd0};
        tbl[10] = '{4'b0110, 4'b0010, 2'd2};
        tbl[11] = '{4'b0101, 4'b0100, 2'd3};
        tbl[12] = '{4'b0001, 4'b0001, 2'd1};
        tbl[13] = '{4'b0000, 4'b0000, 2'd1};

        ex_val    = '0;
        rst       = 1'b1;
        exp_count = 32'd0;
        last      = '{default: '0};
        for (int i = 0; i < N; i++) begin
            seq_a[i] = '0; waddr_a[i] = '0; wdata_a[i] = '0; wen_a[i] = 1'b0;
        end

        cycle(4'b0000, 1'b1, 4'b0000, 2'd0);

        // Single pipe transfer, then idle holds data.
        seq_a[2] = 8'd5; waddr_a[2] = 5'd3; wdata_a[2] = 32'hDEADBEEF; wen_a[2] = 1'b1;
        cycle(4'b0100, 1'b0, 4'b0100, 2'd3);
        chk("single_count", cmp_count, 32'd1);
        cycle(4'b0000, 1'b0, 4'b0000, 2'd3);

        // Write to x0 is suppressed but still reported.
        seq_a[0] = 8'h22; waddr_a[0] = 5'd0; wdata_a[0] = 32'h12345678; wen_a[0] = 1'b1;
        cycle(4'b0001, 1'b0, 4'b0001, 2'd1);

        // Fairness: all pipes requesting for 8 cycles from reset.
        cycle(4'b0000, 1'b1, 4'b0000, 2'd0);
        for (int k = 0; k < 8; k++) begin
            randomize_data();
            cycle(4'b1111, 1'b0, 4'(1 << (k % 4)), 2'((k + 1) % 4));
        end
        chk("fair_count", cmp_count, 32'd8);

        // Reset in the middle of traffic.
        randomize_data();
        cycle(4'b0011, 1'b0, 4'b0001, 2'd1);
        cycle(4'b0011, 1'b1, 4'b0000, 2'd0);
        randomize_data();
        cycle(4'b0011, 1'b0, 4'b0001, 2'd1);

        // Table of vectors from a fresh reset.
        cycle(4'b0000, 1'b1, 4'b0000, 2'd0);
        for (int v = 0; v < 14; v++) begin
            randomize_data();
            cycle(tbl[v].val, 1'b0, tbl[v].rdy, tbl[v].ptr);
        end

        // Count wrap from all-ones.
        @(negedge clk);
        force dut.cmp_count_q = 32'hFFFFFFFF;
        #1;
        release dut.cmp_count_q;
        exp_count = 32'hFFFFFFFF;
        randomize_data();
        cycle(4'b0001, 1'b0, 4'b0001, 2'd1);
        chk("wrap_count", cmp_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
